energy_log_readout: RTL
=======================

Name: energy_log_readout

Overview:
Read-out side of the sample data path: the data collector writes converted-voltage samples into a small sample RAM, and this block drains them to an external host.
- On a start pulse, it reads a run of samples over a synchronous read port.
- It wraps them in a framed byte stream (header, length, samples, checksum).
- It serialises the stream as UART 8N1 on a single tx pin.
- The top level instantiates it beside the data collector and drives tx onto one uo_out bit.

Parameters:
ADDR_W, 4, sample RAM address width; DEPTH = 2**ADDR_W entries.
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range >= 4.
HDR_BYTE, 8'hA5, frame header value.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset. The top level derives it by inverting the codebase's rst_n.
start  in  1  one-cycle request to send a frame; sampled on a rising clk edge.
start_addr  in  ADDR_W  first RAM address to read; captured when start is accepted.
count  in  ADDR_W+1  number of samples to send; captured when start is accepted.
mem_rd_en  out  1  RAM read strobe.
mem_rd_addr  out  ADDR_W  RAM read address.
mem_rd_data  in  8  RAM read data; valid exactly 1 cycle after a mem_rd_en cycle.
tx  out  1  UART serial output; idle high.
busy  out  1  high from start acceptance until the cycle done pulses.
done  out  1  one-cycle pulse after the final stop bit.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, done=0, mem_rd_en=0, mem_rd_addr=0.
  - FSM=IDLE; all counters and checksum cleared.
  - Reset mid-frame abandons the frame immediately: tx returns high with no completion and no done pulse.
- Start acceptance:
  - start is accepted only in IDLE.
  - start while busy=1 or in the done cycle is ignored. No queuing, captured values unchanged.
  - On acceptance: latch start_addr. Latch N = min(count, DEPTH); count > DEPTH is clamped.
  - busy=1 from the next cycle.
- Frame format: HDR_BYTE, then N (8-bit, zero-extended), then N samples, then SUM.
  - SUM = 8-bit modular sum of the length byte and all sample bytes; the header is excluded.
  - N=0 gives the 3-byte frame A5 00 00.
- UART framing:
  - Each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - The first start bit begins the cycle after acceptance.
  - Bytes are back-to-back: the next start bit begins the cycle after the previous stop bit ends.
  - Total frame = (N+3)*10*CLKS_PER_BIT cycles.
  - done pulses in the cycle after the final stop bit ends; busy falls in that same cycle.
- Memory reads:
  - Sample k is read from address (start_addr + k) mod DEPTH; addresses wrap.
  - Each sample is prefetched while the previous byte shifts out, so the RAM's 1-cycle latency never adds a gap.
  - mem_rd_en pulses exactly once per sample, N pulses in total.
  - mem_rd_addr holds its value between reads.
- FSM states: IDLE -> HDR -> LEN -> (N>0 ? DATA : SUM) -> DATA (repeat until N sent) -> SUM -> FIN -> IDLE.
  - FIN is the one-cycle done state.
  - Each state advances only when the serialiser reports byte complete.
- Width rules:
  - Sample index counter is ADDR_W+1 bits, so N=DEPTH is representable.
  - Checksum accumulator is 8 bits and wraps silently.

Decomposition:
- Shared package holds:
  - the frame state enum;
  - HDR_BYTE;
  - the UART constants: START_BIT=0, STOP_BIT=1, BITS_PER_FRAME=10.
- One sub-module, uart_tx_byte:
  - inputs: load, byte[7:0]; outputs: tx, ready, byte_done;
  - contains the bit-timing counter and shift register;
  - the parent owns the FSM, addressing and checksum.

Test Plan:
- RAM[2..4]=10,20,30; start_addr=2, count=3 (CLKS_PER_BIT=16) -> decoded bytes A5 03 10 20 30 63; done exactly 6*160 cycles after acceptance; 3 mem_rd_en pulses at addresses 2,3,4.
- count=0 -> bytes A5 00 00; no mem_rd_en pulses; done after 480 cycles.
- start_addr=14, count=4 -> reads addresses 14,15,0,1 in order; checksum matches the modular sum.
- RAM contents FF,FF, count=2 -> SUM = 02+FF+FF mod 256 = 00; count=20 with DEPTH=16 -> length byte 10, 16 samples sent.
- Second start pulse at mid-frame and in the done cycle -> ignored; exactly one frame emitted; latched address and count unchanged.
- rst asserted during the 2nd data byte -> tx=1 and busy=0 the same cycle, no done; a new start afterwards gives a complete correct frame.

Source files
------------

// File: rtl/energy_log_readout_pkg.sv
// Shared types and constants for the sample read-out frame path.
package energy_log_readout_pkg;

    // Which byte of the frame is currently being shifted out.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN,
        ST_DATA,
        ST_SUM,
        ST_FIN
    } frame_state_t;

    localparam logic [7:0]  HDR_BYTE       = 8'hA5;

    localparam logic        START_BIT      = 1'b0;
    localparam logic        STOP_BIT       = 1'b1;
    localparam int unsigned BITS_PER_FRAME = 10;

endpackage

// File: rtl/energy_log_readout_if.sv
// Synchronous sample-RAM read port: one-cycle read latency.
interface energy_log_readout_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data
    );
endinterface

// File: rtl/energy_log_readout_uart.sv
// UART 8N1 byte serialiser. A new byte may be loaded in the final cycle of
// the previous stop bit, giving back-to-back bytes with no idle gap.
module uart_tx_byte
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data_byte,
    output logic       tx,
    output logic       ready,
    output logic       byte_done
);
    import energy_log_readout_pkg::*;

    localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST = 4'(BITS_PER_FRAME - 1);

    logic [BITS_PER_FRAME-1:0] shreg_q;
    logic [CNT_W-1:0]          clk_cnt_q;
    logic [3:0]                bit_cnt_q;
    logic                      active_q;

    assign byte_done = active_q && (clk_cnt_q == CNT_LAST) && (bit_cnt_q == BIT_LAST);
    assign ready     = !active_q || byte_done;
    // Idle fill of the shifter is all ones, so tx rests high without a mux.
    assign tx        = shreg_q[0];

    // Bit timing and LSB-first shifting of start/data/stop bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '1;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            active_q  <= 1'b0;
        end else if (load && ready) begin
            shreg_q   <= {STOP_BIT, data_byte, START_BIT};
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            active_q  <= 1'b1;
        end else if (active_q) begin
            if (clk_cnt_q == CNT_LAST) begin
                clk_cnt_q <= '0;
                shreg_q   <= {STOP_BIT, shreg_q[BITS_PER_FRAME-1:1]};
                if (bit_cnt_q == BIT_LAST) begin
                    active_q  <= 1'b0;
                    bit_cnt_q <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else begin
                clk_cnt_q <= clk_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/energy_log_readout.sv
// Drains a run of samples from the sample RAM as a framed UART byte stream:
// header, length, samples, 8-bit checksum of length and samples.
module energy_log_readout
#(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  HDR_BYTE     = energy_log_readout_pkg::HDR_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W:0]       count,
    energy_log_readout_if.master  mem,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    import energy_log_readout_pkg::*;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    frame_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   sent_q;
    logic [ADDR_W:0]   fetch_q;
    logic [7:0]        sum_q;
    logic [7:0]        sample_q;
    logic              rd_valid_q;

    logic              accept;
    logic              ld;
    logic              ld_len;
    logic              ld_sample;
    logic [7:0]        ld_byte;
    logic              issue_rd;
    logic              uart_load;
    logic              uart_ready;
    logic              uart_done;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk       (clk),
        .rst       (rst),
        .load      (uart_load),
        .data_byte (ld_byte),
        .tx        (tx),
        .ready     (uart_ready),
        .byte_done (uart_done)
    );

    assign uart_load = ld && uart_ready;
    // The next sample is fetched while the byte just loaded shifts out, so it
    // is sitting in sample_q long before the serialiser asks for it.
    assign issue_rd  = (ld_len || ld_sample) && (fetch_q < n_q);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done      = (state_q == ST_FIN);

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and byte selection; each step waits for byte completion.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        ld        = 1'b0;
        ld_len    = 1'b0;
        ld_sample = 1'b0;
        ld_byte   = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    ld      = 1'b1;
                    ld_byte = HDR_BYTE;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (uart_done) begin
                    ld      = 1'b1;
                    ld_len  = 1'b1;
                    ld_byte = 8'(n_q);
                    state_d = ST_LEN;
                end
            end
            ST_LEN, ST_DATA: begin
                if (uart_done) begin
                    ld = 1'b1;
                    if (sent_q < n_q) begin
                        ld_sample = 1'b1;
                        ld_byte   = sample_q;
                        state_d   = ST_DATA;
                    end else begin
                        ld_byte   = sum_q;
                        state_d   = ST_SUM;
                    end
                end
            end
            ST_SUM: begin
                if (uart_done) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture of the request, RAM addressing, sample prefetch and checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q          <= '0;
            n_q             <= '0;
            sent_q          <= '0;
            fetch_q         <= '0;
            sum_q           <= '0;
            sample_q        <= '0;
            rd_valid_q      <= 1'b0;
            mem.mem_rd_en   <= 1'b0;
            mem.mem_rd_addr <= '0;
        end else begin
            mem.mem_rd_en <= issue_rd;
            rd_valid_q    <= mem.mem_rd_en;

            if (accept) begin
                addr_q  <= start_addr;
                n_q     <= (count > DEPTH) ? DEPTH : count;
                sent_q  <= '0;
                fetch_q <= '0;
                sum_q   <= '0;
            end

            if (issue_rd) begin
                mem.mem_rd_addr <= addr_q;
                addr_q          <= addr_q + ADDR_W'(1);
                fetch_q         <= fetch_q + (ADDR_W+1)'(1);
            end

            if (rd_valid_q) begin
                sample_q <= mem.mem_rd_data;
            end

            if (ld_len) begin
                sum_q <= 8'(n_q);
            end else if (ld_sample) begin
                sum_q  <= sum_q + sample_q;
                sent_q <= sent_q + (ADDR_W+1)'(1);
            end
        end
    end

endmodule
